// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a wrap-around range of register-file indices through
// one read port and streams each captured word, tagged with its index, over a
// valid/ready interface. Used for debug dump, context save and bench checking
// while the core is stalled; it never writes the register file.
module reg_dump_reader #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [SIZE-1:0]  first_reg_i,
    input  logic [SIZE-1:0]  last_reg_i,
    output logic [SIZE-1:0]  read_register_o,
    input  logic [WIDTH-1:0] read_data_i,
    output logic [WIDTH-1:0] dump_data_o,
    output logic [SIZE-1:0]  dump_addr_o,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SIZE-1:0]  ptr_q, ptr_d;
    logic [SIZE-1:0]  last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SIZE-1:0]  addr_q, addr_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             handshake;
    logic             at_last;

    // The consumer takes the word only while a word is actually presented.
    assign handshake = valid_q && dump_ready_i;
    assign at_last   = (ptr_q == last_q);

    // Next-state and datapath updates; every register holds unless a state acts.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ptr_d   = first_reg_i;
                    last_d  = last_reg_i;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Snapshot the read port now so later register-file writes
                // cannot disturb a word that is waiting for the consumer.
                data_d  = read_data_i;
                addr_d  = ptr_q;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (at_last) begin
                        state_d = DONE;
                    end else begin
                        // Natural SIZE-bit overflow gives the wrap from the
                        // top index back to 0.
                        ptr_d   = ptr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Status flags are registered decodes of the state being entered.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign read_register_o = ptr_q;
    assign dump_data_o     = data_q;
    assign dump_addr_o     = addr_q;
    assign dump_valid_o    = valid_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential read-side client of the MIPS register file: on a start pulse it walks a contiguous, wrap-around range of register indices through one register-file read port. It streams each captured word, tagged with its index, over a valid/ready interface. It sits beside the datapath for debug dump, context save and testbench checking, and drives `read_register_*` while the core is stalled.

## Interface
Parameters:
- `WIDTH`, 32, data width of one register.
- `SIZE`, 5, index width; the register space holds 2^SIZE entries.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; when it is 0, all state clears immediately.
- `start_i`  in  1  1-cycle request to begin a dump; sampled only in IDLE.
- `first_reg_i`  in  SIZE  first index of the range; latched on an accepted start.
- `last_reg_i`  in  SIZE  last index of the range, inclusive; latched on an accepted start.
- `read_register_o`  out  SIZE  index driven to the register-file read-port select.
- `read_data_i`  in  WIDTH  combinational read data returned by the register file for `read_register_o`.
- `dump_data_o`  out  WIDTH  captured register word.
- `dump_addr_o`  out  SIZE  index of `dump_data_o`.
- `dump_valid_o`  out  1  `dump_data_o` and `dump_addr_o` are valid.
- `dump_ready_i`  in  1  the consumer accepts a word when both valid and ready are 1.
- `busy_o`  out  1  high from the cycle after an accepted start until DONE ends.
- `done_o`  out  1  1-cycle pulse after the last word is accepted.

## Operation
- States are IDLE, FETCH, SEND and DONE. Encode them in a registered state variable.
- IDLE:
  - If `start_i`=1, latch `ptr`←`first_reg_i` and `last`←`last_reg_i`, then go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - `read_register_o`=`ptr`, driven from a register.
  - At the clock edge, capture `dump_data_o`←`read_data_i` and `dump_addr_o`←`ptr`, set `dump_valid_o`←1, and go to SEND.
- SEND:
  - Hold `dump_data_o`, `dump_addr_o` and `dump_valid_o` stable while `dump_ready_i`=0.
  - The captured word does not change even if the register file is written during the stall.
  - On handshake with `ptr`==`last`: clear valid and go to DONE.
  - On handshake with `ptr`!=`last`: clear valid, set `ptr`←`ptr`+1 modulo 2^SIZE, and go to FETCH.
- DONE: `done_o`=1 for exactly one cycle, then go to IDLE.
- Range arithmetic:
  - The word count is ((`last`−`first`) mod 2^SIZE)+1.
  - `first`==`last` produces exactly 1 word.
  - `first`>`last` wraps from 2^SIZE−1 through 0. For example, first=30, last=1 produces 30, 31, 0, 1.
  - A full 32-word dump is first=0, last=31, or equivalently first=k, last=k−1.
- Index 0 is read like any other entry. The block does not special-case $zero; it reports whatever the register file returns.
- `start_i` is ignored outside IDLE. A start that arrives in the DONE cycle is lost.
- `read_register_o` holds `ptr` in every state. In IDLE it holds the last index used, or 0 after reset.
- The block never writes the register file and has no write-port outputs.

## Timing
- Reset values: state=IDLE, `ptr`=0, `read_register_o`=0, `dump_data_o`=0, `dump_addr_o`=0, `dump_valid_o`=0, `busy_o`=0, `done_o`=0.
- Start latency: start is accepted at edge 0. FETCH is active during cycle 1, and `dump_valid_o`=1 from edge 1, i.e. in cycle 2.
- Throughput with `dump_ready_i` held at 1: one word per 2 cycles. An N-word dump completes with the `done_o` pulse 2N+1 cycles after the start edge.
- `busy_o`=1 in FETCH, SEND and DONE, and is a registered decode of state.
- `done_o` is registered and high only in DONE.
- When `dump_ready_i` is already 1 as valid rises, the handshake completes in the first SEND cycle. No combinational path runs from `dump_ready_i` to any output.
- Reset asserted mid-dump: all outputs return to reset values asynchronously. There is no `done_o` pulse, and the partial dump is abandoned. After reset releases, the block waits in IDLE for a new start.
- Stalls may be any length. Data and index stay bit-stable, and `ptr` does not advance.

## Test plan
- Single word: registers preloaded R5=0xDEADBEEF; start with first=5, last=5, ready=1 -> one word (addr 5, data 0xDEADBEEF) with valid in cycle 2; `done_o` pulses in cycle 3; `busy_o` falls in cycle 4.
- Full dump: R[i]=i·0x01010101; first=0, last=31, ready=1 -> 32 words in index order 0..31 with matching data; `done_o` pulses 65 cycles after the start edge.
- Wrap-around with backpressure: first=30, last=1; ready toggles 0,0,1 per word -> indices 30, 31, 0, 1 in order; each word holds stable through 2 stall cycles; exactly 4 handshakes occur.
- Snapshot stability: during a SEND stall on index 7 (captured 0x11111111), write R7=0x22222222 -> `dump_data_o` stays 0x11111111 until the handshake.
- Start ignored and mid-operation reset: pulse start while busy -> no effect on range or count. Assert reset during the third word of an 8-word dump -> all outputs go to 0 immediately with no `done_o`. A subsequent start with first=2, last=3 produces exactly words 2 and 3.
